// File: rtl/control_unit_pkg.sv
// control_unit_pkg: shared codes for the copperv control unit.
// Holds the instruction type codes, the datapath select codes with their widths,
// and the sequencer state encoding. CU_ILLEGAL_TRAP_EN adds the HALT state.
package control_unit_pkg;

    localparam int unsigned INST_TYPE_WIDTH    = 3;
    localparam int unsigned ALU_DIN2_SEL_WIDTH = 1;
    localparam int unsigned RD_DIN_SEL_WIDTH   = 1;
    localparam int unsigned PC_NEXT_SEL_WIDTH  = 1;
    localparam int unsigned CU_STATE_WIDTH     = 3;

    // Code 0 and 5..7 are undefined instruction types.
    typedef enum logic [INST_TYPE_WIDTH-1:0] {
        INST_TYPE_ILLEGAL = 3'd0,
        INST_TYPE_IMM     = 3'd1,
        INST_TYPE_INT_IMM = 3'd2,
        INST_TYPE_INT_REG = 3'd3,
        INST_TYPE_BRANCH  = 3'd4
    } inst_type_e;

    typedef enum logic [ALU_DIN2_SEL_WIDTH-1:0] {
        ALU_DIN2_IMM = 1'b0,
        ALU_DIN2_RS2 = 1'b1
    } alu_din2_sel_e;

    typedef enum logic [RD_DIN_SEL_WIDTH-1:0] {
        RD_DIN_IMM = 1'b0,
        RD_DIN_ALU = 1'b1
    } rd_din_sel_e;

    typedef enum logic [PC_NEXT_SEL_WIDTH-1:0] {
        PC_NEXT_INC    = 1'b0,
        PC_NEXT_BRANCH = 1'b1
    } pc_next_sel_e;

    typedef enum logic [CU_STATE_WIDTH-1:0] {
        CU_RESET     = 3'd0,
        CU_FETCH     = 3'd1,
        CU_DECODE    = 3'd2,
        CU_EXEC      = 3'd3,
        CU_WRITEBACK = 3'd4
`ifdef CU_ILLEGAL_TRAP_EN
        , CU_HALT    = 3'd5
`endif
    } cu_state_e;

endpackage

// File: rtl/control_unit_if.sv
// control_unit_if: fetch handshake, decoder input and datapath strobes of the
// control unit. master = control unit side, slave = fetch port / datapath side.
interface control_unit_if;
    import control_unit_pkg::*;

    logic                       inst_fetch;
    logic                       inst_valid;
    logic                       inst_load;
    logic [INST_TYPE_WIDTH-1:0] inst_type;
    logic                       alu_comp;
    logic                       rs1_en;
    logic                       rs2_en;
    logic                       alu_en;
    alu_din2_sel_e              alu_din2_sel;
    logic                       rd_en;
    rd_din_sel_e                rd_din_sel;
    logic                       pc_en;
    pc_next_sel_e               pc_next_sel;
    logic                       inst_retired;
    logic                       halted;

    modport master (
        input  inst_valid, inst_type, alu_comp,
        output inst_fetch, inst_load, rs1_en, rs2_en, alu_en, alu_din2_sel,
               rd_en, rd_din_sel, pc_en, pc_next_sel, inst_retired, halted
    );

    modport slave (
        output inst_valid, inst_type, alu_comp,
        input  inst_fetch, inst_load, rs1_en, rs2_en, alu_en, alu_din2_sel,
               rd_en, rd_din_sel, pc_en, pc_next_sel, inst_retired, halted
    );
endinterface

// File: rtl/control_unit.sv
// control_unit: multi-cycle FETCH -> DECODE -> EXEC -> WRITEBACK sequencer.
// Ports:
//   clk  - core clock, rising edge
//   rst  - synchronous active-low reset
//   bus  - control_unit_if.master: fetch handshake (inst_fetch/inst_valid/inst_load),
//          decoder type (inst_type), branch compare (alu_comp), datapath strobes
//          and selects, inst_retired pulse, halted flag
// Macro CU_ILLEGAL_TRAP_EN: undefined instruction types halt the core until reset;
// without it they retire as NOPs and halted is tied to 0.
module control_unit
    import control_unit_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    control_unit_if.master        bus
);

    cu_state_e     state_q, state_d;
    logic          taken_q, taken_d;

    logic          inst_fetch_c, inst_load_c;
    logic          rs1_en_c, rs2_en_c, alu_en_c, rd_en_c, pc_en_c;
    logic          inst_retired_c, halted_c;
    alu_din2_sel_e alu_din2_sel_c;
    rd_din_sel_e   rd_din_sel_c;
    pc_next_sel_e  pc_next_sel_c;

    // State and branch-taken registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= CU_RESET;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            taken_q <= taken_d;
        end
    end

    // Next state and output decode.
    always_comb begin
        state_d        = state_q;
        taken_d        = taken_q;
        inst_fetch_c   = 1'b0;
        inst_load_c    = 1'b0;
        rs1_en_c       = 1'b0;
        rs2_en_c       = 1'b0;
        alu_en_c       = 1'b0;
        alu_din2_sel_c = ALU_DIN2_IMM;
        rd_en_c        = 1'b0;
        rd_din_sel_c   = RD_DIN_IMM;
        pc_en_c        = 1'b0;
        pc_next_sel_c  = PC_NEXT_INC;
        inst_retired_c = 1'b0;
        halted_c       = 1'b0;

        case (state_q)
            CU_RESET: state_d = CU_FETCH;

            CU_FETCH: begin
                inst_fetch_c = 1'b1;
                // A fetch completing while reset is low is abandoned.
                if (bus.inst_valid && rst) begin
                    inst_load_c = 1'b1;
                    state_d     = CU_DECODE;
                end
            end

            CU_DECODE: begin
                state_d = CU_EXEC;
                case (bus.inst_type)
                    INST_TYPE_IMM:     ;
                    INST_TYPE_INT_IMM: rs1_en_c = 1'b1;
                    INST_TYPE_INT_REG,
                    INST_TYPE_BRANCH: begin
                        rs1_en_c = 1'b1;
                        rs2_en_c = 1'b1;
                    end
`ifdef CU_ILLEGAL_TRAP_EN
                    default:           state_d = CU_HALT;
`else
                    default:           ;
`endif
                endcase
            end

            CU_EXEC: begin
                state_d = CU_WRITEBACK;
                case (bus.inst_type)
                    INST_TYPE_INT_IMM: alu_en_c = 1'b1;
                    INST_TYPE_INT_REG: begin
                        alu_en_c       = 1'b1;
                        alu_din2_sel_c = ALU_DIN2_RS2;
                    end
                    INST_TYPE_BRANCH: begin
                        alu_en_c       = 1'b1;
                        alu_din2_sel_c = ALU_DIN2_RS2;
                        taken_d        = bus.alu_comp;
                    end
                    default: ;
                endcase
            end

            CU_WRITEBACK: begin
                state_d        = CU_FETCH;
                pc_en_c        = 1'b1;
                inst_retired_c = 1'b1;
                case (bus.inst_type)
                    INST_TYPE_IMM: rd_en_c = 1'b1;
                    INST_TYPE_INT_IMM,
                    INST_TYPE_INT_REG: begin
                        rd_en_c      = 1'b1;
                        rd_din_sel_c = RD_DIN_ALU;
                    end
                    INST_TYPE_BRANCH:
                        pc_next_sel_c = taken_q ? PC_NEXT_BRANCH : PC_NEXT_INC;
                    default: ;
                endcase
            end

`ifdef CU_ILLEGAL_TRAP_EN
            CU_HALT: halted_c = 1'b1;
`endif

            default: state_d = CU_RESET;
        endcase
    end

    assign bus.inst_fetch   = inst_fetch_c;
    assign bus.inst_load    = inst_load_c;
    assign bus.rs1_en       = rs1_en_c;
    assign bus.rs2_en       = rs2_en_c;
    assign bus.alu_en       = alu_en_c;
    assign bus.alu_din2_sel = alu_din2_sel_c;
    assign bus.rd_en        = rd_en_c;
    assign bus.rd_din_sel   = rd_din_sel_c;
    assign bus.pc_en        = pc_en_c;
    assign bus.pc_next_sel  = pc_next_sel_c;
    assign bus.inst_retired = inst_retired_c;
    assign bus.halted       = halted_c;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: randomized instruction stream against a per-instruction
// cycle model of the control unit; outputs sampled 1 time unit after the
// falling edge that drives the inputs for that cycle.
module tb_control_unit;
    import control_unit_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    control_unit_if bus ();

    control_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    int errors = 0;
    int checks = 0;

    // Observed output word, one bit per output.
    localparam logic [11:0] F_FETCH = 12'h800;
    localparam logic [11:0] F_LOAD  = 12'h400;
    localparam logic [11:0] F_RS1   = 12'h200;
    localparam logic [11:0] F_RS2   = 12'h100;
    localparam logic [11:0] F_ALU   = 12'h080;
    localparam logic [11:0] F_DIN2  = 12'h040;
    localparam logic [11:0] F_RD    = 12'h020;
    localparam logic [11:0] F_RDSEL = 12'h010;
    localparam logic [11:0] F_PC    = 12'h008;
    localparam logic [11:0] F_PCSEL = 12'h004;
    localparam logic [11:0] F_RET   = 12'h002;
    localparam logic [11:0] F_HALT  = 12'h001;
    localparam logic [11:0] NONE    = 12'h000;

    function automatic logic [11:0] obs();
        return {bus.inst_fetch, bus.inst_load, bus.rs1_en, bus.rs2_en, bus.alu_en,
                bus.alu_din2_sel, bus.rd_en, bus.rd_din_sel, bus.pc_en,
                bus.pc_next_sel, bus.inst_retired, bus.halted};
    endfunction

    task automatic check_val(input string tag, input logic [11:0] got, input logic [11:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [2:0] rnd3();
        return 3'($urandom_range(0, 7));
    endfunction

    function automatic logic rnd1();
        return 1'($urandom_range(0, 1));
    endfunction

    // Drive one cycle of inputs at the falling edge, then settle.
    task automatic drive(input logic r, input logic v, input logic [2:0] t, input logic c);
        @(negedge clk);
        rst            = r;
        bus.inst_valid = v;
        bus.inst_type  = t;
        bus.alu_comp   = c;
        #1;
    endtask

    // Hold reset for n cycles, then release; the release cycle is the RESET state.
    task automatic apply_reset(input int n);
        for (int i = 0; i < n; i++) begin
            drive(1'b0, (i == 0) ? 1'b1 : rnd1(), rnd3(), rnd1());
            if (i == 0) check_val("rst_no_load", obs() & F_LOAD, NONE);
            else        check_val("rst_hold", obs(), NONE);
        end
        drive(1'b1, rnd1(), rnd3(), rnd1());
        check_val("rst_release", obs(), NONE);
    endtask

    // One instruction: delay idle fetch cycles, load, decode, exec, writeback.
    // abort_at >= 0 pulls reset in that cycle of the instruction instead.
    task automatic run_inst(input logic [2:0] t, input int delay, input logic comp,
                            input int abort_at);
        logic legal, r1, r2, wr, from_alu, br;
        legal    = t inside {INST_TYPE_IMM, INST_TYPE_INT_IMM, INST_TYPE_INT_REG, INST_TYPE_BRANCH};
        r1       = t inside {INST_TYPE_INT_IMM, INST_TYPE_INT_REG, INST_TYPE_BRANCH};
        r2       = t inside {INST_TYPE_INT_REG, INST_TYPE_BRANCH};
        wr       = t inside {INST_TYPE_IMM, INST_TYPE_INT_IMM, INST_TYPE_INT_REG};
        from_alu = t inside {INST_TYPE_INT_IMM, INST_TYPE_INT_REG};
        br       = (t == INST_TYPE_BRANCH);
        for (int k = 0; k <= delay + 3; k++) begin
            if (k == abort_at) begin
                apply_reset(2);
                return;
            end
            if (k < delay) begin
                drive(1'b1, 1'b0, rnd3(), rnd1());
                check_val("fetch_wait", obs(), F_FETCH);
            end else if (k == delay) begin
                drive(1'b1, 1'b1, rnd3(), rnd1());
                check_val("fetch_load", obs(), F_FETCH | F_LOAD);
            end else if (k == delay + 1) begin
                drive(1'b1, rnd1(), t, rnd1());
                check_val("decode", obs(), (r1 ? F_RS1 : NONE) | (r2 ? F_RS2 : NONE));
`ifdef CU_ILLEGAL_TRAP_EN
                if (!legal) begin
                    for (int h = 0; h < 24; h++) begin
                        drive(1'b1, rnd1(), rnd3(), rnd1());
                        check_val("halt", obs(), F_HALT);
                    end
                    apply_reset(2);
                    return;
                end
`endif
            end else if (k == delay + 2) begin
                drive(1'b1, rnd1(), t, comp);
                check_val("exec", obs(), (r1 ? F_ALU : NONE) | (r2 ? F_DIN2 : NONE));
            end else begin
                // alu_comp randomized here: only the EXEC sample may matter.
                drive(1'b1, rnd1(), t, rnd1());
                check_val("writeback", obs(), F_PC | F_RET | (wr ? F_RD : NONE)
                          | (from_alu ? F_RDSEL : NONE) | ((br && comp) ? F_PCSEL : NONE));
            end
        end
        if (!legal) checks = checks + 0;
    endtask

    initial begin
        rst            = 1'b0;
        bus.inst_valid = 1'b0;
        bus.inst_type  = '0;
        bus.alu_comp   = 1'b0;
        apply_reset(3);

        // Directed cases.
        run_inst(3'(INST_TYPE_INT_REG), 0, 1'b0, -1);
        run_inst(3'(INST_TYPE_IMM),     3, 1'b1, -1);
        run_inst(3'(INST_TYPE_BRANCH),  0, 1'b1, -1);
        run_inst(3'(INST_TYPE_BRANCH),  1, 1'b0, -1);
        run_inst(3'(INST_TYPE_INT_IMM), 2, 1'b1, -1);
        run_inst(3'(INST_TYPE_INT_REG), 3, 1'b0, 2);   // reset mid-fetch
        run_inst(3'(INST_TYPE_IMM),     0, 1'b0, -1);
        run_inst(3'(INST_TYPE_INT_IMM), 0, 1'b0, 2);   // reset in EXEC
        run_inst(3'(INST_TYPE_BRANCH),  0, 1'b1, -1);
        run_inst(3'(INST_TYPE_ILLEGAL), 1, 1'b1, -1);
        run_inst(3'(INST_TYPE_INT_REG), 0, 1'b1, -1);

        // Randomized stream including undefined types and occasional resets.
        for (int n = 0; n < 150; n++) begin
            int d;
            int ab;
            d  = int'($urandom_range(0, 3));
            ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, d + 3)) : -1;
            run_inst(rnd3(), d, rnd1(), ab);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
